sdram_arbiter: RTL and testbench

Single-owner arbiter for the SDRAM command/data pins. It sits between the SDRAM initialisation, auto-refresh, write and read sub-controllers and the physical SDRAM interface. It holds the pins for the init sequence, then grants them to one requester at a time: refresh has absolute priority, and write/read alternate on contention. It multiplexes the granted requester's command, bank, address and write data onto the pins, and a grant-length watchdog recovers from a requester that never signals completion.

---
 rtl/sdram_arbiter.sv | 156 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Single-owner arbiter for the SDRAM command/data pins.
// Init first, then refresh-priority grants with write/read alternation and a grant watchdog.
module sdram_arbiter #(
    parameter logic [15:0] TIMEOUT_CLK = 16'd2000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        init_end,
    input  logic        aref_req,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        aref_end,
    input  logic        wr_req,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_sdram_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        wr_end,
    input  logic        rd_req,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_sdram_addr,
    input  logic        rd_end,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        INIT,
        ARBIT,
        AREF,
        WRITE,
        READ
    } state_t;

    state_t      state_q, state_d;
    logic        last_wr_q, last_wr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic        end_hit;
    logic [3:0]  cmd;

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        cnt_d     = '0;
        tmo_d     = 1'b0;
        end_hit   = 1'b0;
        case (state_q)
            INIT: begin
                if (init_end) state_d = ARBIT;
            end
            ARBIT: begin
                if (aref_req) begin
                    state_d = AREF;
                end else if (wr_req && rd_req) begin
                    // on contention, grant whichever side did not go last
                    state_d   = last_wr_q ? READ : WRITE;
                    last_wr_d = ~last_wr_q;
                end else if (wr_req) begin
                    state_d   = WRITE;
                    last_wr_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = READ;
                    last_wr_d = 1'b0;
                end
            end
            AREF, WRITE, READ: begin
                end_hit = (state_q == AREF  && aref_end)
                       || (state_q == WRITE && wr_end)
                       || (state_q == READ  && rd_end);
                cnt_d = cnt_q + 16'd1;
                if (end_hit) begin
                    state_d = ARBIT;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_CLK - 16'd1) begin
                    state_d = ARBIT;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= INIT;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    // pin mux is combinational from state so registered commands pass same cycle
    always_comb begin
        cmd        = 4'b0111;
        sdram_ba   = 2'b11;
        sdram_addr = 13'h1fff;
        case (state_q)
            INIT: begin
                cmd        = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            AREF: begin
                cmd        = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_sdram_addr;
            end
            READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_sdram_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

    assign aref_en      = (state_q == AREF);
    assign wr_en        = (state_q == WRITE);
    assign rd_en        = (state_q == READ);
    assign sdram_cke    = 1'b1;
    assign sdram_dq_oe  = (state_q == WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : 16'h0;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios with randomized
// payloads, then random traffic, all checked against an ownership model.
module tb_sdram_arbiter;

    localparam int TMO = 16;

    logic        sys_clk;
    logic        sys_rst;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        init_end;
    logic        aref_req;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        aref_end;
    logic        wr_req;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_sdram_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        wr_end;
    logic        rd_req;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_sdram_addr;
    logic        rd_end;
    logic        aref_en;
    logic        wr_en;
    logic        rd_en;
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        timeout_err;

    sdram_arbiter #(.TIMEOUT_CLK(16'(TMO))) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .init_cmd      (init_cmd),
        .init_ba       (init_ba),
        .init_addr     (init_addr),
        .init_end      (init_end),
        .aref_req      (aref_req),
        .aref_cmd      (aref_cmd),
        .aref_ba       (aref_ba),
        .aref_addr     (aref_addr),
        .aref_end      (aref_end),
        .wr_req        (wr_req),
        .wr_cmd        (wr_cmd),
        .wr_ba         (wr_ba),
        .wr_sdram_addr (wr_sdram_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .wr_end        (wr_end),
        .rd_req        (rd_req),
        .rd_cmd        (rd_cmd),
        .rd_ba         (rd_ba),
        .rd_sdram_addr (rd_sdram_addr),
        .rd_end        (rd_end),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .sdram_cke     (sdram_cke),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq_out  (sdram_dq_out),
        .sdram_dq_oe   (sdram_dq_oe),
        .timeout_err   (timeout_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    bit hold_init = 1'b0;
    bit hold_data = 1'b0;

    // reference model: who owns the pins and how long they have held them
    typedef enum int {O_INIT, O_IDLE, O_AREF, O_WR, O_RD} own_t;
    own_t m_own;
    bit   m_last_wr;
    int   m_held;
    bit   m_tmo;

    function automatic void m_reset();
        m_own     = O_INIT;
        m_last_wr = 1'b0;
        m_held    = 0;
        m_tmo     = 1'b0;
    endfunction

    function automatic void m_update();
        bit ended;
        m_tmo = 1'b0;
        case (m_own)
            O_INIT: if (init_end) m_own = O_IDLE;
            O_IDLE: begin
                m_held = 1;
                if (aref_req) m_own = O_AREF;
                else if (wr_req && (!rd_req || !m_last_wr)) begin
                    m_own = O_WR;
                    m_last_wr = 1'b1;
                end else if (rd_req) begin
                    m_own = O_RD;
                    m_last_wr = 1'b0;
                end
            end
            default: begin
                ended = (m_own == O_AREF && aref_end)
                     || (m_own == O_WR && wr_end)
                     || (m_own == O_RD && rd_end);
                if (ended) m_own = O_IDLE;
                else if (m_held == TMO) begin
                    m_own = O_IDLE;
                    m_tmo = 1'b1;
                end else m_held++;
            end
        endcase
    endfunction

    function automatic logic [2:0] exp_grant();
        case (m_own)
            O_AREF:  return 3'b100;
            O_WR:    return 3'b010;
            O_RD:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] exp_pins();
        case (m_own)
            O_INIT:  return {init_cmd, init_ba, init_addr};
            O_AREF:  return {aref_cmd, aref_ba, aref_addr};
            O_WR:    return {wr_cmd, wr_ba, wr_sdram_addr};
            O_RD:    return {rd_cmd, rd_ba, rd_sdram_addr};
            default: return {4'b0111, 2'b11, 13'h1fff};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        logic [16:0] edq;
        edq = (m_own == O_WR && wr_sdram_en) ? {1'b1, wr_sdram_data} : 17'h0;
        chk("grant", 32'({aref_en, wr_en, rd_en}), 32'(exp_grant()));
        chk("pins", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n,
                         sdram_we_n, sdram_ba, sdram_addr}), 32'(exp_pins()));
        chk("dq", 32'({sdram_dq_oe, sdram_dq_out}), 32'(edq));
        chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
        chk("cke", 32'(sdram_cke), 32'd1);
    endtask

    task automatic step();
        aref_cmd      = 4'($urandom);
        aref_ba       = 2'($urandom);
        aref_addr     = 13'($urandom);
        wr_cmd        = 4'($urandom);
        wr_ba         = 2'($urandom);
        wr_sdram_addr = 13'($urandom);
        rd_cmd        = 4'($urandom);
        rd_ba         = 2'($urandom);
        rd_sdram_addr = 13'($urandom);
        init_ba       = 2'($urandom);
        init_addr     = 13'($urandom);
        if (!hold_init) init_cmd = 4'($urandom);
        if (!hold_data) wr_sdram_data = 16'($urandom);
        #1 compare();
        @(posedge sys_clk);
        m_update();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        m_reset();
        #1 compare();
        @(posedge sys_clk);
        @(negedge sys_clk);
        compare();
        sys_rst = 1'b0;
    endtask

    task automatic wait_grant(string tag);
        int n;
        n = 0;
        while (m_own != O_WR && m_own != O_RD && m_own != O_AREF && n < 8) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 8), 32'd1);
    endtask

    initial begin
        int cnt;
        int tcnt;
        bit seen_wr;
        logic [1:0] alt_exp [4];
        sys_rst = 1'b1;
        init_cmd = 4'b0010; init_ba = '0; init_addr = '0; init_end = 1'b0;
        aref_req = 1'b0; aref_cmd = '0; aref_ba = '0; aref_addr = '0;
        aref_end = 1'b0; wr_req = 1'b0; wr_cmd = '0; wr_ba = '0;
        wr_sdram_addr = '0; wr_sdram_en = 1'b0; wr_sdram_data = '0;
        wr_end = 1'b0; rd_req = 1'b0; rd_cmd = '0; rd_ba = '0;
        rd_sdram_addr = '0; rd_end = 1'b0;

        // init handoff
        hold_init = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("init_cmd_pins", 32'({sdram_cs_n, sdram_ras_n,
                                      sdram_cas_n, sdram_we_n}), 32'h2);
        end
        init_end = 1'b1;
        step();
        chk("init_exit_nop", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n,
                                  sdram_we_n, sdram_addr}), 32'({4'b0111, 13'h1fff}));
        step();

        // priority: refresh beats both, then write wins the first tie
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        chk("prio_aref_en", 32'(aref_en), 32'd1);
        aref_req = 1'b0;
        step(); step();
        aref_end = 1'b1;
        step();
        aref_end = 1'b0;
        chk("prio_gap", 32'({aref_en, wr_en, rd_en}), 32'd0);
        step();
        chk("prio_wr_first", 32'({wr_en, rd_en}), 32'b10);
        wr_req = 1'b0; rd_req = 1'b0;
        step();
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        step();

        // alternation
        do_reset();
        step();
        wr_req = 1'b1; rd_req = 1'b1;
        alt_exp[0] = 2'b10; alt_exp[1] = 2'b01;
        alt_exp[2] = 2'b10; alt_exp[3] = 2'b01;
        for (int g = 0; g < 4; g++) begin
            wait_grant("alt_wait");
            chk("alt_order", 32'({wr_en, rd_en}), 32'(alt_exp[g]));
            cnt = 0;
            for (int k = 1; k <= 10; k++) begin
                if (wr_en || rd_en) cnt++;
                wr_end = (k == 10) && alt_exp[g][1];
                rd_end = (k == 10) && alt_exp[g][0];
                step();
            end
            wr_end = 1'b0; rd_end = 1'b0;
            chk("alt_len", 32'(cnt), 32'd10);
            chk("alt_gap", 32'({aref_en, wr_en, rd_en}), 32'd0);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        step(); step();

        // data path in write, then in read
        wr_req = 1'b1;
        wait_grant("dq_wr_wait");
        wr_req = 1'b0;
        hold_data = 1'b1;
        wr_sdram_data = 16'hA5A5;
        for (int i = 0; i < 4; i++) begin
            wr_sdram_en = 1'b1;
            #1 chk("dq_wr_oe", 32'({sdram_dq_oe, sdram_dq_out}), 32'h1A5A5);
            step();
        end
        wr_sdram_en = 1'b0;
        #1 chk("dq_wr_off", 32'({sdram_dq_oe, sdram_dq_out}), 32'h0);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        rd_req = 1'b1;
        wait_grant("dq_rd_wait");
        rd_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_sdram_en = 1'b1;
            #1 chk("dq_rd_oe", 32'({sdram_dq_oe, sdram_dq_out}), 32'h0);
            step();
        end
        wr_sdram_en = 1'b0;
        hold_data = 1'b0;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        step();

        // watchdog on a read that never ends, with a write pending
        do_reset();
        step();
        rd_req = 1'b1;
        wait_grant("wd_wait");
        rd_req = 1'b0;
        wr_req = 1'b1;
        cnt = 0; tcnt = 0; seen_wr = 1'b0;
        for (int i = 0; i < 40 && !seen_wr; i++) begin
            if (rd_en) cnt++;
            if (timeout_err) tcnt++;
            if (wr_en) seen_wr = 1'b1;
            else step();
        end
        chk("wd_rd_len", 32'(cnt), TMO);
        chk("wd_err_pulses", 32'(tcnt), 32'd1);
        chk("wd_wr_next", 32'(seen_wr), 32'd1);
        wr_req = 1'b0;

        // reset while writing
        wr_sdram_en = 1'b1;
        step();
        do_reset();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_dq_oe", 32'(sdram_dq_oe), 32'd0);
        wr_sdram_en = 1'b0;
        hold_init = 1'b0;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            aref_req    = ($urandom_range(0, 15) == 0);
            wr_req      = 1'($urandom);
            rd_req      = 1'($urandom);
            wr_sdram_en = 1'($urandom);
            aref_end    = ($urandom_range(0, 5) == 0);
            wr_end      = ($urandom_range(0, 9) == 0);
            rd_end      = ($urandom_range(0, 9) == 0);
            init_end    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
